sram_fifo_fwft: RTL and testbench
=================================

// Module: sram_fifo_fwft
// PURPOSE
//  Parametrised synchronous first-word-fall-through FIFO built on an internal 1R1W registered-read memory array.
//  The array is equivalent to the sky130 1r1w SRAM macro, generalised in width and depth.
//  Hides the array's one-cycle read latency behind a 2-entry prefetch buffer, so a full-throughput valid/ready stream passes at 1 word/clk.
//  Sits between a producer and a consumer in the same clock domain. Replaces direct macro instantiation in the FIFO datapath.
// PARAMETERS
//  DATA_WIDTH   8                  word width in bits
//  ADDR_WIDTH   4                  memory address width; array depth = 1<<ADDR_WIDTH
//  DEPTH        1<<ADDR_WIDTH      total FIFO capacity (array + prefetch); must equal 1<<ADDR_WIDTH
//  AF_LEVEL     DEPTH-2            almost_full asserted when count >= AF_LEVEL
//  AE_LEVEL     2                  almost_empty asserted when count <= AE_LEVEL
// PORTS
//  clk           in   1               single clock, all state on posedge
//  rst           in   1               asynchronous, active-high reset
//  in_valid      in   1               producer has a word
//  in_ready      out  1               FIFO can accept; push = in_valid & in_ready
//  in_data       in   DATA_WIDTH      write data
//  out_valid     out  1               out_data holds the oldest word
//  out_ready     in   1               consumer takes word; pop = out_valid & out_ready
//  out_data      out  DATA_WIDTH      head word (registered)
//  count         out  ADDR_WIDTH+1    words held (array + prefetch), 0..DEPTH
//  almost_full   out  1               count >= AF_LEVEL
//  almost_empty  out  1               count <= AE_LEVEL
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - wr_ptr, rd_ptr, prefetch occupancy, count all 0.
//   - out_valid=0, in_ready=1, almost_empty=1, almost_full=0, out_data=0.
//   - Array contents are not cleared.
//   - Reset mid-transfer discards all held words; any read in flight is dropped.
//  Registered outputs: in_ready = (count<DEPTH). There is no combinational path from out_ready to in_ready.
//  Push: mem[wr_ptr] <= in_data; wr_ptr increments modulo 1<<ADDR_WIDTH (natural wrap).
//  Read issue:
//   - Issued in a cycle when the array holds >=1 unread word and prefetch occupancy + reads in flight < 2.
//   - The read registers rd_ptr; data lands in the prefetch buffer next posedge; rd_ptr increments with wrap.
//  No read/write collision: a read only targets a word written in an earlier cycle.
//  Latency: a word pushed into an empty FIFO at edge N is available as out_valid=1 after edge N+2.
//  Steady state: sustained push and pop every cycle give 1 word/clk with no bubbles.
//  Prefetch buffer:
//   - 2 entries; head drives out_data/out_valid.
//   - On pop the second entry (or the landing read data) moves to the head in the same edge.
//   - out_data is stable while out_valid=1 and out_ready=0.
//  count:
//   - +1 on push only, -1 on pop only, unchanged on push+pop.
//   - Never exceeds DEPTH or goes below 0.
//  Full (count==DEPTH): in_ready=0, so no push is accepted even if a pop occurs the same cycle; in_ready rises the cycle after the pop.
//  Empty: out_valid=0; out_ready is ignored; no pop.
//  in_data/in_valid while in_ready=0 are ignored (backpressure, not an error).
//  Flags are recomputed from the next count and registered with it.
// TESTING
//  1 Reset then single push 0xA5 at edge 0 -> out_valid=1 after edge 2, out_data=0xA5, count=1; pop -> count=0, out_valid=0.
//  2 Fill 16 words 0x00..0x0F with out_ready=0 -> in_ready=0 after 16th push, count=16, almost_full=1 from count=14; extra push 0xFF ignored.
//  3 Full FIFO, pop and in_valid same cycle -> push rejected, count=15; next cycle push accepted, count=16; drain order 0x01..0x0F then new word.
//  4 Stream 40 words with in_valid=out_ready=1 continuously -> after 2-cycle fill, one word out per clk, in order, pointers wrap twice, count constant.
//  5 Random in_valid/out_ready (50%) over 1000 words vs scoreboard -> identical order, no loss or duplication, out_data stable while stalled.
//  6 Assert rst mid-stream with count=7 and a read in flight -> out_valid=0 and count=0 immediately; next push 0x3C appears first, no stale data.

Source files
------------

// File: rtl/sram_fifo_fwft.sv
// First-word-fall-through FIFO on a 1R1W registered-read array.
// A 2-entry prefetch buffer hides the read latency so streams pass at 1 word/clk.
module sram_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);
    localparam logic [CW-1:0] AF_L    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CW-1:0]         mem_cnt_r;
    logic                  rd_busy_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic [1:0]            pf_cnt_r;
    logic [DATA_WIDTH-1:0] pf_sec_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  issue_s;
    logic [1:0]            pf_base_s;
    logic [1:0]            pf_cnt_nxt_s;
    logic [DATA_WIDTH-1:0] head_nxt_s;
    logic [DATA_WIDTH-1:0] sec_nxt_s;
    logic [CW-1:0]         count_nxt_s;
    logic [CW-1:0]         mem_cnt_nxt_s;

    assign push_s = in_valid & in_ready;
    assign pop_s  = out_valid & out_ready;

    // A pop in this cycle frees a prefetch slot, so it may fund a new read now.
    assign issue_s = (mem_cnt_r != {CW{1'b0}}) &&
                     (({1'b0, pf_cnt_r} + {2'b00, rd_busy_r}) < (3'd2 + {2'b00, pop_s}));

    // Next prefetch contents: drop head on pop, then append the landing read word.
    always_comb begin
        pf_base_s    = pf_cnt_r - {1'b0, pop_s};
        pf_cnt_nxt_s = pf_base_s + {1'b0, rd_busy_r};
        head_nxt_s   = out_data;
        sec_nxt_s    = pf_sec_r;
        if (pop_s) begin
            head_nxt_s = pf_sec_r;
        end else begin
            head_nxt_s = out_data;
        end
        if (rd_busy_r) begin
            if (pf_base_s == 2'd0) begin
                head_nxt_s = rd_data_r;
            end else begin
                sec_nxt_s = rd_data_r;
            end
        end else begin
            sec_nxt_s = pf_sec_r;
        end
    end

    // Occupancy bookkeeping for the whole FIFO and for unread array words.
    always_comb begin
        count_nxt_s = count;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count - {{(CW-1){1'b0}}, 1'b1};
            default: count_nxt_s = count;
        endcase
        mem_cnt_nxt_s = mem_cnt_r;
        case ({push_s, issue_s})
            2'b10:   mem_cnt_nxt_s = mem_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   mem_cnt_nxt_s = mem_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            default: mem_cnt_nxt_s = mem_cnt_r;
        endcase
    end

    // Array write port and registered read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_r] <= in_data;
        end
        if (issue_s) begin
            rd_data_r <= mem[rd_ptr_r];
        end
    end

    // Control state, prefetch buffer and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
            mem_cnt_r    <= {CW{1'b0}};
            rd_busy_r    <= 1'b0;
            pf_cnt_r     <= 2'd0;
            pf_sec_r     <= {DATA_WIDTH{1'b0}};
            out_data     <= {DATA_WIDTH{1'b0}};
            out_valid    <= 1'b0;
            count        <= {CW{1'b0}};
            in_ready     <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            mem_cnt_r    <= mem_cnt_nxt_s;
            rd_busy_r    <= issue_s;
            pf_cnt_r     <= pf_cnt_nxt_s;
            pf_sec_r     <= sec_nxt_s;
            out_data     <= head_nxt_s;
            out_valid    <= (pf_cnt_nxt_s != 2'd0);
            count        <= count_nxt_s;
            in_ready     <= (count_nxt_s < DEPTH_L);
            almost_full  <= (count_nxt_s >= AF_L);
            almost_empty <= (count_nxt_s <= AE_L);
        end
    end

endmodule

// File: tb/tb_sram_fifo_fwft.sv
// Self-checking bench for sram_fifo_fwft: directed scenarios plus a randomized
// stream against a queue-based reference model.
module tb_sram_fifo_fwft;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       almost_full;
    logic       almost_empty;

    int checks = 0;
    int failures = 0;

    // Reference model: words held in order with the edge index they were pushed on.
    logic [7:0] q[$];
    int         qt[$];
    int         ecnt = 0;
    bit         m_push;
    bit         m_pop;

    sram_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    // The oldest word is visible once two edges have passed since its push edge.
    function automatic bit mvalid();
        return (q.size() > 0) && (ecnt >= qt[0] + 3);
    endfunction

    task automatic model_clear();
        q.delete();
        qt.delete();
        ecnt = 0;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        m_push = v && (q.size() < 16);
        m_pop  = r && mvalid();
        @(posedge clk);
        if (!rst) begin
            if (m_pop) begin
                void'(q.pop_front());
                void'(qt.pop_front());
            end
            if (m_push) begin
                q.push_back(d);
                qt.push_back(ecnt);
            end
            ecnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 5'd0 ||
            almost_empty !== 1'b1 || almost_full !== 1'b0 || out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset: ov=%b ir=%b cnt=%0d ae=%b af=%b od=%h required ov=0 ir=1 cnt=0 ae=1 af=0 od=00",
                     out_valid, in_ready, count, almost_empty, almost_full, out_data);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 8'hA5, 1'b0);
        checks++;
        if (count !== 5'd1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_edge0: cnt=%0d ov=%b required cnt=1 ov=0", count, out_valid);
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_edge1: ov=%b required 0", out_valid);
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 5'd1) begin
            failures++;
            $display("FAIL single_edge2: ov=%b od=%h cnt=%0d required ov=1 od=a5 cnt=1", out_valid, out_data, count);
        end
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            failures++;
            $display("FAIL single_pop: ov=%b cnt=%0d required ov=0 cnt=0", out_valid, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            checks++;
            if (count !== 5'(i + 1) || almost_full !== ((i + 1) >= 14) || in_ready !== ((i + 1) < 16)) begin
                failures++;
                $display("FAIL fill_%0d: cnt=%0d af=%b ir=%b required cnt=%0d af=%b ir=%b",
                         i, count, almost_full, in_ready, i + 1, (i + 1) >= 14, (i + 1) < 16);
            end
        end
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (count !== 5'd16 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h00) begin
            failures++;
            $display("FAIL fill_extra: cnt=%0d ir=%b ov=%b od=%h required cnt=16 ir=0 ov=1 od=00",
                     count, in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp;
        int wait_cyc;
        drive(1'b1, 8'hAA, 1'b1);
        checks++;
        if (count !== 5'd15 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_reject: cnt=%0d ir=%b required cnt=15 ir=1", count, in_ready);
        end
        drive(1'b1, 8'hAA, 1'b0);
        checks++;
        if (count !== 5'd16 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_accept: cnt=%0d ir=%b required cnt=16 ir=0", count, in_ready);
        end
        for (int k = 0; k < 16; k++) begin
            exp = (k < 15) ? 8'(k + 1) : 8'hAA;
            wait_cyc = 0;
            while (out_valid !== 1'b1 && wait_cyc < 4) begin
                drive(1'b0, 8'h00, 1'b0);
                wait_cyc++;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                failures++;
                $display("FAIL drain_%0d: ov=%b od=%h required ov=1 od=%h", k, out_valid, out_data, exp);
            end
            drive(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_empty: cnt=%0d ov=%b ae=%b required cnt=0 ov=0 ae=1", count, out_valid, almost_empty);
        end
    endtask

    task automatic test_back_to_back();
        int rx = 0;
        for (int i = 0; i < 40; i++) begin
            if (i >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || count !== 5'd3) begin
                    failures++;
                    $display("FAIL stream_steady_%0d: ov=%b cnt=%0d required ov=1 cnt=3", i, out_valid, count);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== 8'(rx * 7 + 3)) begin
                    failures++;
                    $display("FAIL stream_data_%0d: od=%h required %h", rx, out_data, 8'(rx * 7 + 3));
                end
                rx++;
            end
            drive(1'b1, 8'(i * 7 + 3), 1'b1);
        end
        for (int c = 0; c < 20 && rx < 40; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== 8'(rx * 7 + 3)) begin
                    failures++;
                    $display("FAIL stream_data_%0d: od=%h required %h", rx, out_data, 8'(rx * 7 + 3));
                end
                rx++;
            end
            drive(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (rx != 40 || count !== 5'd0) begin
            failures++;
            $display("FAIL stream_total: rx=%0d cnt=%0d required rx=40 cnt=0", rx, count);
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        int popped = 0;
        bit v;
        bit r;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        for (int c = 0; c < 8000 && popped < 1000; c++) begin
            checks++;
            if (in_ready !== (q.size() < 16) || out_valid !== mvalid() || count !== 5'(q.size()) ||
                almost_full !== (q.size() >= 14) || almost_empty !== (q.size() <= 2)) begin
                failures++;
                $display("FAIL rand_status_%0d: ir=%b ov=%b cnt=%0d af=%b ae=%b required ir=%b ov=%b cnt=%0d af=%b ae=%b",
                         c, in_ready, out_valid, count, almost_full, almost_empty,
                         q.size() < 16, mvalid(), q.size(), q.size() >= 14, q.size() <= 2);
            end
            if (mvalid()) begin
                checks++;
                if (out_data !== q[0]) begin
                    failures++;
                    $display("FAIL rand_data_%0d: od=%h required %h", popped, out_data, q[0]);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_data !== prev_data) begin
                    failures++;
                    $display("FAIL rand_stable_%0d: od=%h required %h", c, out_data, prev_data);
                end
            end
            v = (pushed < 1000) && ($urandom_range(1, 0) == 1);
            r = ($urandom_range(1, 0) == 1);
            prev_stall = (out_valid === 1'b1) && !r;
            prev_data  = out_data;
            drive(v, 8'($urandom), r);
            if (m_push) pushed++;
            if (m_pop) popped++;
        end
        checks++;
        if (pushed != 1000 || popped != 1000 || count !== 5'd0) begin
            failures++;
            $display("FAIL rand_total: pushed=%0d popped=%0d cnt=%0d required 1000 1000 0", pushed, popped, count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h50 + i), 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h77, 1'b1);
        checks++;
        if (count !== 5'd7) begin
            failures++;
            $display("FAIL mid_pre: cnt=%0d required 7", count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 5'd0 || in_ready !== 1'b1 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: ov=%b cnt=%0d ir=%b ae=%b required ov=0 cnt=0 ir=1 ae=1",
                     out_valid, count, in_ready, almost_empty);
        end
        model_clear();
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'h3C, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || count !== 5'd1) begin
            failures++;
            $display("FAIL mid_first: ov=%b od=%h cnt=%0d required ov=1 od=3c cnt=1", out_valid, out_data, count);
        end
        drive(1'b0, 8'h00, 1'b1);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            failures++;
            $display("FAIL mid_no_stale: ov=%b cnt=%0d required ov=0 cnt=0", out_valid, count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
